// File: rtl/johnson_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_sequencer
//  Description : Owns and sequences a WIDTH-bit Johnson (twisted-ring) phase
//                counter. Supports start / stop / single-step control,
//                direction select, a programmable lap target, pattern preload
//                and detection of illegal preload patterns.
//  Ports       : clk         - clock, rising edge
//                rst_n       - asynchronous active-low reset
//                start_i     - start from IDLE / resume from PAUSE
//                stop_i      - pause in RUN / abort to IDLE from PAUSE
//                step_i      - single advance in IDLE or PAUSE
//                dir_i       - 1 = forward, 0 = reverse
//                laps_i      - lap target (0 = run until stopped)
//                ld_i        - load ld_val_i into phase (IDLE only)
//                ld_val_i    - pattern to load
//                phase_o     - Johnson pattern
//                phase_idx_o - index of phase in the forward sequence
//                busy_o      - state is RUN or PAUSE
//                lap_o       - one-cycle pulse, wrap on previous edge
//                done_o      - one-cycle pulse, lap target reached
//                err_o       - sticky, illegal pattern was loaded
//  Revision    : 1.0 - initial release
// ============================================================================
module johnson_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             step_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] laps_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    output logic [WIDTH-1:0] phase_o,
    output logic [IDX_W-1:0] phase_idx_o,
    output logic             busy_o,
    output logic             lap_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // A Johnson pattern has at most one boundary between its run of ones
    // and its run of zeros.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (v[i] != v[i+1]) n++;
        end
        return (n <= 1);
    endfunction

    // Ones fill from the LSB during the first half-revolution and drain from
    // the LSB during the second, so the popcount plus the MSB gives the index.
    function automatic logic [IDX_W-1:0] pattern_idx(input logic [WIDTH-1:0] v);
        int pop;
        pop = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) pop++;
        end
        if (v[WIDTH-1]) return IDX_W'(2*WIDTH - pop);
        else            return IDX_W'(pop);
    endfunction

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   phase_q,   phase_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [CNT_W-1:0]   lap_cnt_q, lap_cnt_d;
    logic [CNT_W-1:0]   laps_q,    laps_d;
    logic               busy_q,    busy_d;
    logic               lap_q,     lap_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;

    logic               adv;
    logic               count;
    logic               wrap;
    logic [CNT_W-1:0]   lap_cnt_inc;

    assign lap_cnt_inc = lap_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        lap_cnt_d = lap_cnt_q;
        laps_d    = laps_q;
        err_d     = err_q;
        lap_d     = 1'b0;
        done_d    = 1'b0;
        adv       = 1'b0;
        count     = 1'b0;
        wrap      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop has no meaning in IDLE, so it is not decoded here
                if (start_i) begin
                    state_d   = S_RUN;
                    lap_cnt_d = '0;
                    err_d     = 1'b0;
                    laps_d    = laps_i;
                end else if (step_i) begin
                    adv = 1'b1;
                end else if (ld_i) begin
                    if (is_legal(ld_val_i)) begin
                        phase_d = ld_val_i;
                        idx_d   = pattern_idx(ld_val_i);
                    end else begin
                        phase_d = '0;
                        idx_d   = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    state_d = S_PAUSE;
                end else begin
                    adv   = 1'b1;
                    count = 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (start_i) begin
                    state_d = S_RUN;
                end else if (step_i) begin
                    adv   = 1'b1;
                    count = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adv) begin
            if (dir_i) begin
                phase_d = {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                wrap    = (idx_q == LAST_IDX);
            end else begin
                phase_d = {~phase_q[0], phase_q[WIDTH-1:1]};
                idx_d   = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
                wrap    = (idx_q == '0);
            end
        end

        if (wrap) begin
            lap_d = 1'b1;
            if (count) begin
                lap_cnt_d = lap_cnt_inc;
                if ((laps_q != '0) && (lap_cnt_inc == laps_q)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
        end

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            lap_cnt_q <= '0;
            laps_q    <= '0;
            busy_q    <= 1'b0;
            lap_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            lap_cnt_q <= lap_cnt_d;
            laps_q    <= laps_d;
            busy_q    <= busy_d;
            lap_q     <= lap_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign phase_o     = phase_q;
    assign phase_idx_o = idx_q;
    assign busy_o      = busy_q;
    assign lap_o       = lap_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_johnson_sequencer
//  Description : Directed vector bench for johnson_sequencer (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_i, stop_i, step_i, dir_i, ld_i;
    logic [7:0] laps_i;
    logic [3:0] ld_val_i;
    logic [3:0] phase_o;
    logic [2:0] phase_idx_o;
    logic       busy_o, lap_o, done_o, err_o;

    int n_cmp = 0;
    int n_bad = 0;

    johnson_sequencer #(.WIDTH(4), .CNT_W(8), .IDX_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .step_i      (step_i),
        .dir_i       (dir_i),
        .laps_i      (laps_i),
        .ld_i        (ld_i),
        .ld_val_i    (ld_val_i),
        .phase_o     (phase_o),
        .phase_idx_o (phase_idx_o),
        .busy_o      (busy_o),
        .lap_o       (lap_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, step, dir, ld;
        logic [3:0] ld_val;
        logic [7:0] laps;
        logic [3:0] ph;
        logic [2:0] idx;
        logic       busy, lap, done, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic se,
                                input logic d, input logic l,
                                input logic [3:0] lv, input logic [7:0] lp,
                                input logic [3:0] ph, input logic [2:0] ix,
                                input logic b, input logic lpo,
                                input logic dn, input logic e);
        vec_t v;
        v.start = st; v.stop = sp; v.step = se; v.dir = d; v.ld = l;
        v.ld_val = lv; v.laps = lp;
        v.ph = ph; v.idx = ix; v.busy = b; v.lap = lpo; v.done = dn; v.err = e;
        return v;
    endfunction

    // Output bundle: {phase, idx, busy, lap, done, err}
    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ph/idx/busy/lap/done/err=%b required %b", name, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {phase_o, phase_idx_o, busy_o, lap_o, done_o, err_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start_i = 0; stop_i = 0; step_i = 0; ld_i = 0; ld_val_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fwd_seq [8];
        fwd_seq[0] = 4'b0001; fwd_seq[1] = 4'b0011; fwd_seq[2] = 4'b0111; fwd_seq[3] = 4'b1111;
        fwd_seq[4] = 4'b1110; fwd_seq[5] = 4'b1100; fwd_seq[6] = 4'b1000; fwd_seq[7] = 4'b0000;

        // Forward, two laps: one start cycle, 16 advances, back to IDLE
        vecs.push_back(mk(1,0,0,1,0,4'h0,8'd2, 4'b0000,3'd0, 1,0,0,0));
        for (int k = 0; k < 16; k++) begin
            vecs.push_back(mk(0,0,0,1,0,4'h0,8'd2, fwd_seq[k%8], 3'((k+1)%8),
                              (k != 15), (k == 7 || k == 15), (k == 15), 0));
        end
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd2, 4'b0000,3'd0, 0,0,0,0));

        // Pause / step / resume / abort, laps=0 (unbounded)
        vecs.push_back(mk(1,0,0,1,0,4'h0,8'd0, 4'b0000,3'd0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd0, 4'b0001,3'd1, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd0, 4'b0011,3'd2, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd0, 4'b0111,3'd3, 1,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,4'h0,8'd0, 4'b0111,3'd3, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd0, 4'b0111,3'd3, 1,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,4'h0,8'd0, 4'b1111,3'd4, 1,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,4'h0,8'd0, 4'b1110,3'd5, 1,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,4'h0,8'd0, 4'b1110,3'd5, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd0, 4'b1100,3'd6, 1,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,4'h0,8'd0, 4'b1100,3'd6, 1,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,4'h0,8'd0, 4'b1100,3'd6, 0,0,0,0));
        // Priority: start+stop in RUN pauses, start+stop+step in PAUSE aborts
        vecs.push_back(mk(1,0,0,1,0,4'h0,8'd0, 4'b1100,3'd6, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd0, 4'b1000,3'd7, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd0, 4'b0000,3'd0, 1,1,0,0));
        vecs.push_back(mk(1,1,0,1,0,4'h0,8'd0, 4'b0000,3'd0, 1,0,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0,8'd0, 4'b0000,3'd0, 0,0,0,0));

        // Load legality and ignoring ld outside IDLE
        vecs.push_back(mk(0,0,0,1,1,4'b0101,8'd0, 4'b0000,3'd0, 0,0,0,1));
        vecs.push_back(mk(0,0,0,1,1,4'b1100,8'd0, 4'b1100,3'd6, 0,0,0,1));
        vecs.push_back(mk(0,0,0,1,1,4'b0111,8'd0, 4'b0111,3'd3, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0,4'h0,8'd0, 4'b0111,3'd3, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,4'b0101,8'd0, 4'b1111,3'd4, 1,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,4'h0,8'd0, 4'b1111,3'd4, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,4'b0001,8'd0, 4'b1111,3'd4, 1,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,4'h0,8'd0, 4'b1111,3'd4, 0,0,0,0));
        // IDLE step reverse, then step beats ld
        vecs.push_back(mk(0,0,1,0,0,4'h0,8'd0, 4'b0111,3'd3, 0,0,0,0));
        vecs.push_back(mk(0,0,1,1,1,4'b1100,8'd0, 4'b1111,3'd4, 0,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,4'b0000,8'd0, 4'b0000,3'd0, 0,0,0,0));

        // Reverse, laps=1: leaving home crosses idx 0 -> 7, which is a wrap
        vecs.push_back(mk(1,0,0,0,0,4'h0,8'd1, 4'b0000,3'd0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'h0,8'd1, 4'b1000,3'd7, 0,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,4'h0,8'd1, 4'b1000,3'd7, 0,0,0,0));

        // Direction change mid-run, laps=2; lap count restarts at start
        vecs.push_back(mk(1,0,0,0,0,4'h0,8'd2, 4'b1000,3'd7, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'h0,8'd2, 4'b1100,3'd6, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd2, 4'b1000,3'd7, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd2, 4'b0000,3'd0, 1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'h0,8'd2, 4'b1000,3'd7, 0,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,4'h0,8'd2, 4'b1000,3'd7, 0,0,0,0));

        // A step in PAUSE can complete the final lap
        vecs.push_back(mk(1,0,0,1,0,4'h0,8'd1, 4'b1000,3'd7, 1,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,4'h0,8'd1, 4'b1000,3'd7, 1,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,4'h0,8'd1, 4'b0000,3'd0, 0,1,1,0));
        vecs.push_back(mk(0,0,0,1,0,4'h0,8'd1, 4'b0000,3'd0, 0,0,0,0));

        // Reset state
        rst_n = 1'b0; drive_idle(); dir_i = 1'b1; laps_i = '0;
        tick(); tick();
        check("reset_state", outs(), 11'b0000_000_0000);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start_i  = vecs[i].start;
            stop_i   = vecs[i].stop;
            step_i   = vecs[i].step;
            dir_i    = vecs[i].dir;
            ld_i     = vecs[i].ld;
            ld_val_i = vecs[i].ld_val;
            laps_i   = vecs[i].laps;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].ph, vecs[i].idx, vecs[i].busy, vecs[i].lap, vecs[i].done, vecs[i].err});
        end
        drive_idle();

        // Asynchronous reset clears a sticky err without a clock edge
        ld_i = 1'b1; ld_val_i = 4'b1010;
        tick();
        drive_idle();
        check("err_set", outs(), 11'b0000_000_0001);
        rst_n = 1'b0;
        #2;
        check("async_rst_err", outs(), 11'b0000_000_0000);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a run
        start_i = 1'b1; dir_i = 1'b1; laps_i = 8'd0;
        tick();
        start_i = 1'b0;
        tick(); tick();
        check("run_before_rst", outs(), 11'b0011_010_1000);
        rst_n = 1'b0;
        #2;
        check("async_rst_run", outs(), 11'b0000_000_0000);
        tick();
        check("held_in_rst", outs(), 11'b0000_000_0000);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
